clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
- Central user-interface sequencer for the multimodal clock.
- Consumes single-cycle press pulses from three debouncers (mode, select, increment).
- Drives the display-mode, set-field, adjust strobes, alarm enable and stopwatch control for the timekeeping, alarm and stopwatch datapaths.
- Returns from any set state to its view state after an inactivity timeout.

Parameters:
- TIMEOUT_S, 10, seconds without any press before a set state exits to its view state.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_S.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_mode_p  in  1  one-cycle pulse: mode button press
- btn_sel_p  in  1  one-cycle pulse: select button press
- btn_inc_p  in  1  one-cycle pulse: increment button press
- tick_1hz  in  1  one-cycle pulse, once per second, from the prescaler
- disp_mode  out  2  0 = clock, 1 = alarm, 2 = stopwatch; 3 never driven
- set_field  out  2  0 = none, 1 = hours, 2 = minutes
- hold_time  out  1  high while the clock time is being set; freezes timekeeping
- inc_hours  out  1  one-cycle strobe: increment hours of the target selected by inc_alarm
- inc_minutes  out  1  one-cycle strobe: increment minutes of the target selected by inc_alarm
- inc_alarm  out  1  0 = strobes target clock time, 1 = strobes target alarm time
- alarm_en  out  1  alarm armed
- sw_run  out  1  stopwatch running
- sw_clear  out  1  one-cycle strobe: clear stopwatch
- blink  out  1  display blink phase for the field being set

Behaviour:
- Reset (async, active-low): state = V_CLOCK; all outputs 0, except blink = 1; timeout counter = 0.
- States: V_CLOCK, S_TH, S_TM, V_ALARM, S_AH, S_AM, V_SW. All outputs are registered and take effect 1 cycle after the causing pulse.
- Simultaneous pulses: priority is mode > sel > inc. Exactly one press is acted on per cycle; lower-priority presses in that cycle are dropped.
- Mode press:
  - V_CLOCK -> V_ALARM -> V_SW -> V_CLOCK.
  - In S_TH or S_TM -> V_CLOCK. In S_AH or S_AM -> V_ALARM. Changes already made are kept.
- Sel press:
  - V_CLOCK -> S_TH -> S_TM -> V_CLOCK.
  - V_ALARM -> S_AH -> S_AM -> V_ALARM.
  - V_SW: toggles sw_run.
- Inc press:
  - S_TH or S_AH: inc_hours = 1 for 1 cycle.
  - S_TM or S_AM: inc_minutes = 1 for 1 cycle.
  - V_ALARM: toggles alarm_en.
  - V_SW with sw_run = 0: sw_clear = 1 for 1 cycle. With sw_run = 1: ignored.
  - V_CLOCK: ignored.
- Output decode:
  - inc_alarm = 1 in S_AH and S_AM, else 0.
  - disp_mode = 0 for V_CLOCK, S_TH, S_TM; 1 for V_ALARM, S_AH, S_AM; 2 for V_SW.
  - set_field = 1 in S_TH and S_AH; 2 in S_TM and S_AM; 0 otherwise.
  - hold_time = 1 only in S_TH and S_TM.
- Stopwatch state persistence:
  - sw_run keeps its value when leaving V_SW; the stopwatch continues in the background.
  - alarm_en keeps its value in all states.
- Blink:
  - Set to 1 on every entry into a set state and on every acted press while in a set state.
  - Toggles on each tick_1hz while in a set state.
  - Forced to 1 in view states.
- Timeout:
  - Counter is cleared on state entry and on any acted press.
  - Increments on tick_1hz only while in a set state.
  - When the counter reaches TIMEOUT_S, the state exits to its view (S_TH/S_TM -> V_CLOCK, S_AH/S_AM -> V_ALARM) on the next cycle, and the counter clears.
  - A press arriving in the same cycle as the expiring tick takes precedence over the timeout.
  - Counter saturates at TIMEOUT_S and never wraps.
- Reset mid-operation: asserting reset during any state, including while a strobe is high, returns all outputs to reset values immediately and asynchronously.

Test Plan:
- Release reset, pulse mode 3 times, 5 cycles apart -> disp_mode goes 1, 2, 0, each 1 cycle after its pulse. All strobes stay 0.
- From V_CLOCK: sel, inc, inc, sel, inc, sel ->
  - hold_time = 1 from first sel to last sel.
  - Two 1-cycle inc_hours strobes, then one inc_minutes strobe, all with inc_alarm = 0.
  - Ends with set_field = 0 and hold_time = 0.
- Mode then sel to reach S_AH, then 10 tick_1hz with no press ->
  - blink toggles each tick.
  - After the 10th tick: state V_ALARM, set_field = 0. No inc strobes.
- In V_ALARM, pulse mode, sel and inc in the same cycle -> only mode acts: disp_mode = 2; alarm_en unchanged; no set state entered.
- In V_SW:
  - inc -> sw_clear pulse.
  - sel -> sw_run = 1; a further inc -> no sw_clear.
  - mode -> disp_mode = 0 with sw_run still 1.
- In S_TM, assert reset coincident with btn_inc_p -> no inc_minutes pulse; all outputs at reset values. After release, state is V_CLOCK.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_mode_ctrl
//  Description : User-interface sequencer for the multimodal clock. Turns
//                mode/select/increment presses into display mode, set-field,
//                adjust strobes, alarm enable and stopwatch control.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int TO_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode_p,
  input  logic       btn_sel_p,
  input  logic       btn_inc_p,
  input  logic       tick_1hz,
  output logic [1:0] disp_mode,
  output logic [1:0] set_field,
  output logic       hold_time,
  output logic       inc_hours,
  output logic       inc_minutes,
  output logic       inc_alarm,
  output logic       alarm_en,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       blink
);

  typedef enum logic [2:0] {
    V_CLOCK = 3'd0,
    S_TH    = 3'd1,
    S_TM    = 3'd2,
    V_ALARM = 3'd3,
    S_AH    = 3'd4,
    S_AM    = 3'd5,
    V_SW    = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT_S);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;

  logic w_mode;
  logic w_sel;
  logic w_inc;
  logic w_press;
  logic w_in_set;
  logic w_nxt_set;
  logic w_alarm_en_nxt;
  logic w_sw_run_nxt;
  logic w_sw_clear_nxt;
  logic w_inc_hours_nxt;
  logic w_inc_minutes_nxt;
  logic w_blink_nxt;

  function automatic logic is_set(input state_t s);
    return (s == S_TH) || (s == S_TM) || (s == S_AH) || (s == S_AM);
  endfunction

  function automatic state_t view_of(input state_t s);
    case (s)
      S_AH, S_AM, V_ALARM: return V_ALARM;
      V_SW:                return V_SW;
      default:             return V_CLOCK;
    endcase
  endfunction

  // Only the highest-priority press in a cycle is acted on
  assign w_mode   = btn_mode_p;
  assign w_sel    = btn_sel_p & ~btn_mode_p;
  assign w_inc    = btn_inc_p & ~btn_mode_p & ~btn_sel_p;
  assign w_press  = btn_mode_p | btn_sel_p | btn_inc_p;
  assign w_in_set = is_set(r_state);

  always_comb begin
    w_state_nxt       = r_state;
    w_to_cnt_nxt      = r_to_cnt;
    w_alarm_en_nxt    = alarm_en;
    w_sw_run_nxt      = sw_run;
    w_sw_clear_nxt    = 1'b0;
    w_inc_hours_nxt   = 1'b0;
    w_inc_minutes_nxt = 1'b0;

    if (w_mode) begin
      case (r_state)
        V_CLOCK: w_state_nxt = V_ALARM;
        V_ALARM: w_state_nxt = V_SW;
        V_SW:    w_state_nxt = V_CLOCK;
        default: w_state_nxt = view_of(r_state);
      endcase
      w_to_cnt_nxt = '0;
    end else if (w_sel) begin
      case (r_state)
        V_CLOCK: w_state_nxt = S_TH;
        S_TH:    w_state_nxt = S_TM;
        S_TM:    w_state_nxt = V_CLOCK;
        V_ALARM: w_state_nxt = S_AH;
        S_AH:    w_state_nxt = S_AM;
        S_AM:    w_state_nxt = V_ALARM;
        V_SW:    w_sw_run_nxt = ~sw_run;
        default: w_state_nxt = V_CLOCK;
      endcase
      w_to_cnt_nxt = '0;
    end else if (w_inc) begin
      case (r_state)
        S_TH, S_AH: w_inc_hours_nxt   = 1'b1;
        S_TM, S_AM: w_inc_minutes_nxt = 1'b1;
        V_ALARM:    w_alarm_en_nxt    = ~alarm_en;
        V_SW:       w_sw_clear_nxt    = ~sw_run;
        default:    ;
      endcase
      w_to_cnt_nxt = '0;
    end else if (w_in_set) begin
      // Counter saturates at the timeout value and forces a return to view
      if (r_to_cnt >= c_timeout) begin
        w_state_nxt  = view_of(r_state);
        w_to_cnt_nxt = '0;
      end else if (tick_1hz) begin
        w_to_cnt_nxt = r_to_cnt + 1'b1;
      end
    end else begin
      w_to_cnt_nxt = '0;
    end

    w_nxt_set = is_set(w_state_nxt);

    if (!w_nxt_set || w_press || !w_in_set) begin
      w_blink_nxt = 1'b1;
    end else if (tick_1hz) begin
      w_blink_nxt = ~blink;
    end else begin
      w_blink_nxt = blink;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= V_CLOCK;
      r_to_cnt    <= '0;
      disp_mode   <= 2'd0;
      set_field   <= 2'd0;
      hold_time   <= 1'b0;
      inc_hours   <= 1'b0;
      inc_minutes <= 1'b0;
      inc_alarm   <= 1'b0;
      alarm_en    <= 1'b0;
      sw_run      <= 1'b0;
      sw_clear    <= 1'b0;
      blink       <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      inc_hours   <= w_inc_hours_nxt;
      inc_minutes <= w_inc_minutes_nxt;
      alarm_en    <= w_alarm_en_nxt;
      sw_run      <= w_sw_run_nxt;
      sw_clear    <= w_sw_clear_nxt;
      blink       <= w_blink_nxt;
      hold_time   <= (w_state_nxt == S_TH) || (w_state_nxt == S_TM);
      inc_alarm   <= (w_state_nxt == S_AH) || (w_state_nxt == S_AM);

      case (w_state_nxt)
        V_ALARM, S_AH, S_AM: disp_mode <= 2'd1;
        V_SW:                disp_mode <= 2'd2;
        default:             disp_mode <= 2'd0;
      endcase

      case (w_state_nxt)
        S_TH, S_AH: set_field <= 2'd1;
        S_TM, S_AM: set_field <= 2'd2;
        default:    set_field <= 2'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_mode_ctrl
//  Description : Directed bench for clock_mode_ctrl with a view/field model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_mode_ctrl;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode_p = 1'b0;
  logic       btn_sel_p = 1'b0;
  logic       btn_inc_p = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [1:0] disp_mode;
  logic [1:0] set_field;
  logic       hold_time;
  logic       inc_hours;
  logic       inc_minutes;
  logic       inc_alarm;
  logic       alarm_en;
  logic       sw_run;
  logic       sw_clear;
  logic       blink;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  clock_mode_ctrl #(.TIMEOUT_S(TO), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .btn_mode_p(btn_mode_p), .btn_sel_p(btn_sel_p), .btn_inc_p(btn_inc_p),
    .tick_1hz(tick_1hz),
    .disp_mode(disp_mode), .set_field(set_field), .hold_time(hold_time),
    .inc_hours(inc_hours), .inc_minutes(inc_minutes), .inc_alarm(inc_alarm),
    .alarm_en(alarm_en), .sw_run(sw_run), .sw_clear(sw_clear), .blink(blink)
  );

  always #5 clk = ~clk;

  // Model: view 0/1/2 = clock/alarm/stopwatch, field 0/1/2 = none/hours/minutes
  typedef struct packed {
    logic [1:0] view;
    logic [1:0] field;
    logic       alarm_en;
    logic       sw_run;
    logic       clr;
    logic       inc_h;
    logic       inc_m;
    logic       blink;
    logic [3:0] cnt;
  } model_t;

  localparam model_t M_RESET = '{view: 2'd0, field: 2'd0, alarm_en: 1'b0, sw_run: 1'b0,
                                 clr: 1'b0, inc_h: 1'b0, inc_m: 1'b0, blink: 1'b1, cnt: 4'd0};

  model_t mdl = M_RESET;

  function automatic model_t step(input model_t c, input logic m, input logic s,
                                  input logic i, input logic t);
    model_t n;
    logic setting;
    n = c;
    n.clr = 1'b0;
    n.inc_h = 1'b0;
    n.inc_m = 1'b0;
    setting = (c.field != 2'd0);
    if (m) begin
      if (setting) n.field = 2'd0;
      else n.view = (c.view == 2'd2) ? 2'd0 : c.view + 2'd1;
      n.cnt = 4'd0;
    end else if (s) begin
      if (!setting && c.view == 2'd2) n.sw_run = ~c.sw_run;
      else n.field = (c.field == 2'd2) ? 2'd0 : c.field + 2'd1;
      n.cnt = 4'd0;
    end else if (i) begin
      if (setting) begin
        if (c.field == 2'd1) n.inc_h = 1'b1;
        else n.inc_m = 1'b1;
      end else if (c.view == 2'd1) n.alarm_en = ~c.alarm_en;
      else if (c.view == 2'd2 && !c.sw_run) n.clr = 1'b1;
      n.cnt = 4'd0;
    end else if (setting) begin
      if (int'(c.cnt) == TO) begin
        n.field = 2'd0;
        n.cnt = 4'd0;
      end else if (t) n.cnt = c.cnt + 4'd1;
    end
    if (n.field == 2'd0 || m || s || i || !setting) n.blink = 1'b1;
    else if (t) n.blink = ~c.blink;
    return n;
  endfunction

  function automatic logic [15:0] m_out(input model_t c);
    return {3'b000, c.view, c.field, (c.view == 2'd0 && c.field != 2'd0), c.inc_h, c.inc_m,
            (c.view == 2'd1 && c.field != 2'd0), c.alarm_en, c.sw_run, c.clr, c.blink};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) mdl <= M_RESET;
    else mdl <= step(mdl, btn_mode_p, btn_sel_p, btn_inc_p, tick_1hz);
  end

  wire [15:0] dut_out = {3'b000, disp_mode, set_field, hold_time, inc_hours, inc_minutes,
                         inc_alarm, alarm_en, sw_run, sw_clear, blink};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) chk("model_outputs", dut_out, m_out(mdl));
  end

  // Called at a falling edge; returns one cycle later with the effect visible
  task automatic press(input logic m, input logic s, input logic i, input logic t);
    btn_mode_p = m;
    btn_sel_p  = s;
    btn_inc_p  = i;
    tick_1hz   = t;
    @(negedge clk);
    btn_mode_p = 1'b0;
    btn_sel_p  = 1'b0;
    btn_inc_p  = 1'b0;
    tick_1hz   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    idle(1);
    chk("reset_vector", dut_out, 16'h0001);

    // Mode cycling
    press(1, 0, 0, 0); chk("mode1_disp", 16'(disp_mode), 16'd1); idle(4);
    press(1, 0, 0, 0); chk("mode2_disp", 16'(disp_mode), 16'd2); idle(4);
    press(1, 0, 0, 0); chk("mode3_disp", 16'(disp_mode), 16'd0); idle(4);

    // Clock time setting
    press(0, 1, 0, 0); chk("sth_hold", 16'({hold_time, set_field}), 16'h5);
    press(0, 0, 1, 0); chk("sth_inc_h", 16'({inc_hours, inc_alarm}), 16'h2);
    idle(1);           chk("sth_inc_h_gap", 16'(inc_hours), 16'd0);
    press(0, 0, 1, 0); chk("sth_inc_h2", 16'(inc_hours), 16'd1);
    press(0, 1, 0, 0); chk("stm_field", 16'(set_field), 16'd2);
    press(0, 0, 1, 0); chk("stm_inc_m", 16'({inc_minutes, inc_hours, inc_alarm}), 16'h4);
    press(0, 1, 0, 0); chk("stm_exit", 16'({hold_time, set_field}), 16'h0);
    idle(2);

    // Alarm hours set state, then inactivity timeout
    press(1, 0, 0, 0);
    press(0, 1, 0, 0); chk("sah_enter", 16'({inc_alarm, set_field, blink}), 16'hB);
    for (int k = 1; k <= TO; k++) begin
      press(0, 0, 0, 1);
      chk("sah_blink", 16'(blink), 16'(k % 2 == 0));
      idle(1);
    end
    chk("timeout_view", 16'({disp_mode, set_field}), 16'h4);
    press(0, 0, 1, 0); chk("alarm_toggle", 16'(alarm_en), 16'd1);

    // Simultaneous presses: mode wins
    press(1, 1, 1, 0);
    chk("prio_mode", 16'({disp_mode, set_field, alarm_en}), 16'h11);

    // Stopwatch
    press(0, 0, 1, 0); chk("sw_clear", 16'(sw_clear), 16'd1);
    press(0, 1, 0, 0); chk("sw_run_on", 16'({sw_run, sw_clear}), 16'h2);
    press(0, 0, 1, 0); chk("sw_no_clear", 16'(sw_clear), 16'd0);
    press(1, 0, 0, 0); chk("sw_bg_run", 16'({disp_mode, sw_run}), 16'h1);

    // Press on the expiring tick beats the timeout
    press(0, 1, 0, 0);
    for (int k = 0; k < TO - 1; k++) begin
      press(0, 0, 0, 1);
      idle(1);
    end
    press(0, 0, 1, 1); chk("press_beats_to", 16'({inc_hours, set_field}), 16'h5);
    idle(3);           chk("to_restarted", 16'(set_field), 16'd1);
    press(1, 0, 0, 0); chk("set_mode_exit", 16'({disp_mode, set_field}), 16'h0);

    // Asynchronous reset in S_TM coincident with an inc press
    press(0, 1, 0, 0);
    press(0, 1, 0, 0); chk("stm_again", 16'(set_field), 16'd2);
    btn_inc_p = 1'b1;
    #2 reset = 1'b0;
    #1 chk("async_reset", dut_out, 16'h0001);
    @(negedge clk);
    btn_inc_p = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    chk("post_reset", dut_out, 16'h0001);
    press(0, 1, 0, 0); chk("post_reset_clock", 16'({hold_time, set_field}), 16'h5);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
